// File: rtl/adc_sweep_ctrl.sv
// adc_sweep_ctrl
// ----------------------------------------------------------------------------
// Sense-amplifier ADC sweep sequencer. A read request enables the sense path,
// walks read_ref from lower_ref up to upper_ref (inclusive), pulses sa_clk once
// per level after read_ref has settled, and samples sa_do in the following
// cycle. Each bit's code is the highest level at which it compared >= (0 if it
// never did). Completion is signalled by a one-cycle done strobe.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   start                 request pulse, honoured only in IDLE
//   lower_ref, upper_ref  inclusive reference range, captured on accepted start
//   busy                  sweep in progress
//   done                  one-cycle completion strobe
//   range_err             valid with done; lower_ref > upper_ref
//   sa_en, sa_clk         sense-amp enable and conversion clock
//   read_ref              current ADC reference level
//   sa_do                 comparator outputs (1: conductance >= read_ref)
//   codes                 per-bit codes, bit i at [i*ADC_BITS +: ADC_BITS]
//
// Optional feature macro: ADC_SWEEP_EARLY_EXIT_EN
//   When defined, a SAMPLE cycle with sa_do all zeros ends the sweep early
//   (assumes comparator results are monotonic in read_ref).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_SETTLE | read_ref held stable, settle counter running down
// ST_CLK_HI | sa_clk high for one cycle
// ST_SAMPLE | sa_do captured into codes, step to next level or finish
// ST_DONE   | done strobe, sense path disabled
// ----------------------------------------------------------------------------
module adc_sweep_ctrl #(
    parameter int WORD_SIZE     = 48,
    parameter int ADC_BITS      = 6,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ADC_BITS-1:0]           lower_ref,
    input  logic [ADC_BITS-1:0]           upper_ref,
    output logic                          busy,
    output logic                          done,
    output logic                          range_err,
    output logic                          sa_en,
    output logic                          sa_clk,
    output logic [ADC_BITS-1:0]           read_ref,
    input  logic [WORD_SIZE-1:0]          sa_do,
    output logic [WORD_SIZE*ADC_BITS-1:0] codes
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CLK_HI,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [ADC_BITS-1:0]           read_ref_q, read_ref_d;
    logic [ADC_BITS-1:0]           upper_q, upper_d;
    logic [WORD_SIZE*ADC_BITS-1:0] codes_q, codes_d;
    logic                          range_err_q, range_err_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          sa_en_q, sa_en_d;
    logic                          sa_clk_q, sa_clk_d;
    logic                          early_stop;

`ifdef ADC_SWEEP_EARLY_EXIT_EN
    assign early_stop = (sa_do == '0);
`else
    assign early_stop = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        read_ref_d  = read_ref_q;
        upper_d     = upper_q;
        codes_d     = codes_q;
        range_err_d = range_err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    codes_d = '0;
                    if (lower_ref > upper_ref) begin
                        range_err_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        range_err_d = 1'b0;
                        upper_d     = upper_ref;
                        read_ref_d  = lower_ref;
                        cnt_d       = CNT_LOAD;
                        state_d     = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_CLK_HI;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CLK_HI: begin
                state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                // Levels only ever increase, so the last level that reads 1
                // overwrites earlier ones and leaves the highest passing level.
                for (int i = 0; i < WORD_SIZE; i++) begin
                    if (sa_do[i]) begin
                        codes_d[i*ADC_BITS +: ADC_BITS] = read_ref_q;
                    end
                end
                // Equality termination lets upper_ref sit at full scale
                // without read_ref ever wrapping.
                if ((read_ref_q == upper_q) || early_stop) begin
                    state_d = ST_DONE;
                end else begin
                    read_ref_d = read_ref_q + 1'b1;
                    cnt_d      = CNT_LOAD;
                    state_d    = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered versions of the next state's decode so they
        // switch on the same edge as the state itself.
        busy_d   = (state_d == ST_SETTLE) || (state_d == ST_CLK_HI) ||
                   (state_d == ST_SAMPLE);
        sa_en_d  = busy_d;
        sa_clk_d = (state_d == ST_CLK_HI);
        done_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            read_ref_q  <= '0;
            upper_q     <= '0;
            codes_q     <= '0;
            range_err_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sa_en_q     <= 1'b0;
            sa_clk_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_ref_q  <= read_ref_d;
            upper_q     <= upper_d;
            codes_q     <= codes_d;
            range_err_q <= range_err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sa_en_q     <= sa_en_d;
            sa_clk_q    <= sa_clk_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign range_err = range_err_q;
    assign sa_en     = sa_en_q;
    assign sa_clk    = sa_clk_q;
    assign read_ref  = read_ref_q;
    assign codes     = codes_q;

endmodule

// File: doc/adc_sweep_ctrl.md
# adc_sweep_ctrl

Sense-amplifier ADC sweep sequencer between the programming FSM read path and the RRAM analog macro. On a read request it enables the sense path, steps `read_ref` through an inclusive ADC reference range, pulses `sa_clk` once per level, and samples `sa_do` after each pulse. Each bit's sampled results are reduced to a per-bit conductance code, returned to the FSM with a one-cycle `done` strobe.

## Interface
- `WORD_SIZE`, 48: bits per RRAM word (`sa_do` width).
- `ADC_BITS`, 6: ADC reference / code width.
- `SETTLE_CYCLES`, 2: cycles `read_ref` is held stable before each `sa_clk` pulse; legal range ≥1.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `lower_ref`  in  ADC_BITS  first reference level; captured on accepted `start`.
- `upper_ref`  in  ADC_BITS  last reference level, inclusive; captured on accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` is high.
- `done`  out  1  one-cycle completion strobe.
- `range_err`  out  1  valid with `done`; high when `lower_ref > upper_ref`.
- `sa_en`  out  1  sense-amp enable to the analog macro.
- `sa_clk`  out  1  sense-amp conversion clock, one cycle high per level.
- `read_ref`  out  ADC_BITS  current ADC reference level.
- `sa_do`  in  WORD_SIZE  comparator outputs; bit i=1 means cell i conductance ≥ `read_ref`.
- `codes`  out  WORD_SIZE*ADC_BITS  per-bit codes; bit i occupies `[i*ADC_BITS +: ADC_BITS]`.

## Operation
- States: IDLE, SETTLE, CLK_HI, SAMPLE, DONE.
- IDLE → SETTLE on `start`, when `lower_ref ≤ upper_ref`.
  - Capture both references.
  - Set `read_ref` to `lower_ref` and `sa_en` to 1.
  - Clear `codes` to 0.
  - Load the settle counter with `SETTLE_CYCLES-1`.
- IDLE → DONE on `start`, when `lower_ref > upper_ref`. Set `range_err`, clear `codes`, leave `sa_en` low.
- SETTLE: decrement the counter. At 0, go to CLK_HI.
- CLK_HI: `sa_clk` is 1 for exactly one cycle, then go to SAMPLE.
- SAMPLE: `sa_clk` is 0.
  - Capture `sa_do` at the end of the cycle.
  - For every bit i with `sa_do[i]=1`, set `codes[i]` to the current `read_ref`. Bits reading 0 keep their previous code.
  - If `read_ref == upper_ref`, go to DONE.
  - Otherwise increment `read_ref`, reload the counter, and go to SETTLE.
  - `read_ref` never wraps; termination is by equality, so `upper_ref = 2^ADC_BITS-1` is legal.
- DONE: `done` is 1 for one cycle, `sa_en` is 0, `busy` is 0. Next state is IDLE.
- `codes` and `range_err` hold their values until the next accepted `start`.
- A code of 0 means the bit never compared ≥, or compared ≥ only at level 0.
- `start` is ignored in every state except IDLE. `start` in the DONE cycle is also ignored.
- Reset mid-sweep: all state returns to reset values immediately and asynchronously. No `done` is produced.

## Timing
- Reset values:
  - state IDLE
  - `busy` 0, `done` 0, `range_err` 0
  - `sa_en` 0, `sa_clk` 0
  - `read_ref` 0
  - `codes` all 0
- All outputs are registered.
- `sa_en`, `read_ref` and `busy` change on the clock edge that accepts `start`.
- `read_ref` is stable for `SETTLE_CYCLES` cycles before `sa_clk` rises. It is also stable during the CLK_HI and SAMPLE cycles.
- `sa_do` must be valid by the end of the cycle after `sa_clk` is high.
- Per level: `SETTLE_CYCLES + 2` cycles.
- Let N = upper_ref - lower_ref + 1.
  - `done` is high in cycle N*(SETTLE_CYCLES+2)+1 after the accepting edge.
  - For a range error, `done` is high in cycle 1.
- `sa_en` falls in the same cycle that `done` rises.

## Configuration
- `ADC_SWEEP_EARLY_EXIT_EN` defined: in SAMPLE, if `sa_do` is all zeros, go to DONE immediately.
  - This relies on comparator results being monotonic in `read_ref`.
  - `codes` keep the values captured so far.
  - `range_err` stays 0.
- Undefined: the full range is always swept, regardless of `sa_do`.

## Test plan
- Reset during SETTLE with `read_ref`=3 → next cycle: `sa_en`=0, `read_ref`=0, `busy`=0, no `done`.
- `SETTLE_CYCLES`=2, `start` with lower=5, upper=5, `sa_do` all ones → exactly one `sa_clk` pulse. `done` in cycle 5. Every code = 5.
- lower=0, upper=3. Model bit0 as 1 while ref ≤ 2, bit1 always 0, bit2 always 1 → codes: bit0=2, bit1=0, bit2=3. `done` in cycle 17. Four `sa_clk` pulses.
- lower=9, upper=4 → `done` and `range_err` in cycle 1. `sa_en` never rises. `codes` = 0.
- lower=62, upper=63 (ADC_BITS=6), `sa_do` all ones → two levels, no wrap. Codes = 63. A second `start` asserted while `busy` is ignored.
- With `ADC_SWEEP_EARLY_EXIT_EN` defined: lower=0, upper=10, all bits 0 from ref 4 → `done` after the ref-4 sample (cycle 21). Codes = 3.
- Same test without the macro → `done` in cycle 45. Codes = 3.
